// File: rtl/raster_scan_addr_gen.sv
// raster_scan_addr_gen
//   Raster-scan pixel address generator for the Floyd-Steinberg datapath. It walks the image
//   one pixel per accepted handshake. For each pixel it emits the linear address, the (x,y)
//   position, and the addresses and in-image valid bits of the 4 error-diffusion neighbours.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     i_start         begin a frame scan (honoured only when idle)
//     i_addr_ready    consumer accepts the current pixel this cycle
//     o_addr_valid    o_cur_* / o_nbr_* are valid (high throughout a scan)
//     o_cur_addr      linear address y*IMAGEX+x
//     o_cur_x/o_cur_y current column / row
//     o_nbr_addr      neighbour addresses, slot 0 in the LSBs (0 for invalid slots)
//     o_nbr_valid     slot k neighbour lies inside the image
//     o_last          current pixel is the final pixel of the frame
//     o_done          one-cycle pulse after the final pixel is accepted
//
//   Build option: define SERPENTINE_EN for a boustrophedon scan. In that mode odd rows run
//   right-to-left and their neighbour slots are mirrored (0=W 1=SE 2=S 3=SW).
module raster_scan_addr_gen #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGEXlog2       = $clog2(IMAGEX),
  parameter int IMAGEYlog2       = $clog2(IMAGEY),
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY),
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic                                 i_addr_ready,
  output logic                                 o_addr_valid,
  output logic [IMAGE_ADDR_WIDTH-1:0]          o_cur_addr,
  output logic [IMAGEXlog2-1:0]                o_cur_x,
  output logic [IMAGEYlog2-1:0]                o_cur_y,
  output logic [ADJ_PIXELS*IMAGE_ADDR_WIDTH-1:0] o_nbr_addr,
  output logic [ADJ_PIXELS-1:0]                o_nbr_valid,
  output logic                                 o_last,
  output logic                                 o_done
);

  localparam logic [IMAGEXlog2-1:0]       XMax  = IMAGEXlog2'(IMAGEX - 1);
  localparam logic [IMAGEYlog2-1:0]       YMax  = IMAGEYlog2'(IMAGEY - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] XStep = IMAGE_ADDR_WIDTH'(IMAGEX);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] AOne  = IMAGE_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                      r_state, w_state_next;
  logic [IMAGEXlog2-1:0]       r_x, w_x_next;
  logic [IMAGEYlog2-1:0]       r_y, w_y_next;
  logic [IMAGE_ADDR_WIDTH-1:0] r_row_base, w_row_base_next;

  logic w_run, w_rev, w_next_row_rev, w_row_end, w_last;

`ifdef SERPENTINE_EN
  // Odd rows scan right-to-left; the row after the current one flips direction.
  assign w_rev          = r_y[0];
  assign w_next_row_rev = ~r_y[0];
`else
  assign w_rev          = 1'b0;
  assign w_next_row_rev = 1'b0;
`endif

  assign w_run     = (r_state == StRun);
  assign w_row_end = w_rev ? (r_x == '0) : (r_x == XMax);
  assign w_last    = w_run && w_row_end && (r_y == YMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_row_base <= w_row_base_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_row_base_next = r_row_base;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StRun;
      end
      StRun: begin
        if (i_addr_ready) begin
          if (w_last) begin
            w_state_next = StDone;
          end else if (w_row_end) begin
            w_y_next        = r_y + IMAGEYlog2'(1);
            w_row_base_next = r_row_base + XStep;
            w_x_next        = w_next_row_rev ? XMax : '0;
          end else begin
            w_x_next = w_rev ? (r_x - IMAGEXlog2'(1)) : (r_x + IMAGEXlog2'(1));
          end
        end
      end
      StDone: begin
        // Rewind so the next frame starts at pixel 0 straight out of idle.
        w_state_next    = StIdle;
        w_x_next        = '0;
        w_y_next        = '0;
        w_row_base_next = '0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Neighbour geometry
  logic [IMAGE_ADDR_WIDTH-1:0] w_cur, w_s;
  logic                        w_has_e, w_has_w, w_has_s;
  logic [IMAGE_ADDR_WIDTH-1:0] w_slot_addr [ADJ_PIXELS];
  logic [ADJ_PIXELS-1:0]       w_slot_vld;

  assign w_cur   = r_row_base + IMAGE_ADDR_WIDTH'(r_x);
  assign w_s     = w_cur + XStep;
  assign w_has_e = w_run && (r_x != XMax);
  assign w_has_w = w_run && (r_x != '0);
  assign w_has_s = w_run && (r_y != YMax);

  always_comb begin
    for (int k = 0; k < ADJ_PIXELS; k++) w_slot_addr[k] = '0;
    w_slot_vld = '0;
    if (w_rev) begin
      w_slot_addr[0] = w_cur - AOne;  w_slot_vld[0] = w_has_w;
      w_slot_addr[1] = w_s + AOne;    w_slot_vld[1] = w_has_e && w_has_s;
      w_slot_addr[2] = w_s;           w_slot_vld[2] = w_has_s;
      w_slot_addr[3] = w_s - AOne;    w_slot_vld[3] = w_has_w && w_has_s;
    end else begin
      w_slot_addr[0] = w_cur + AOne;  w_slot_vld[0] = w_has_e;
      w_slot_addr[1] = w_s - AOne;    w_slot_vld[1] = w_has_w && w_has_s;
      w_slot_addr[2] = w_s;           w_slot_vld[2] = w_has_s;
      w_slot_addr[3] = w_s + AOne;    w_slot_vld[3] = w_has_e && w_has_s;
    end
  end

  always_comb begin
    o_nbr_addr = '0;
    for (int k = 0; k < ADJ_PIXELS; k++) begin
      o_nbr_addr[k*IMAGE_ADDR_WIDTH +: IMAGE_ADDR_WIDTH] = w_slot_vld[k] ? w_slot_addr[k] : '0;
    end
  end

  assign o_nbr_valid  = w_slot_vld;
  assign o_addr_valid = w_run;
  assign o_cur_addr   = w_cur;
  assign o_cur_x      = r_x;
  assign o_cur_y      = r_y;
  assign o_last       = w_last;
  assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_raster_scan_addr_gen.sv
// tb_raster_scan_addr_gen
//   Directed bench for raster_scan_addr_gen on a 4x4 image. Expected addresses follow the
//   scan order of the build (serpentine when SERPENTINE_EN is defined).
module tb_raster_scan_addr_gen;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_addr_ready;
  logic          o_addr_valid;
  logic [AW-1:0] o_cur_addr;
  logic [1:0]    o_cur_x;
  logic [1:0]    o_cur_y;
  logic [4*AW-1:0] o_nbr_addr;
  logic [3:0]    o_nbr_valid;
  logic          o_last;
  logic          o_done;

  int n_checks = 0;
  int n_errors = 0;

  raster_scan_addr_gen #(
    .IMAGEX(X),
    .IMAGEY(Y)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_addr_ready (i_addr_ready),
    .o_addr_valid (o_addr_valid),
    .o_cur_addr   (o_cur_addr),
    .o_cur_x      (o_cur_x),
    .o_cur_y      (o_cur_y),
    .o_nbr_addr   (o_nbr_addr),
    .o_nbr_valid  (o_nbr_valid),
    .o_last       (o_last),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of the i-th pixel visited in a frame.
  function automatic int exp_addr(input int i);
    int y, xi;
    y  = i / X;
    xi = i % X;
`ifdef SERPENTINE_EN
    if (y % 2 == 1) return y * X + (X - 1 - xi);
`endif
    return y * X + xi;
  endfunction

  function automatic logic [AW-1:0] slot(input logic [4*AW-1:0] v, input int k);
    return v[k*AW +: AW];
  endfunction

  initial begin
    int  idx;
    bit  done_seen;
    bit  was_acc;

    rst = 1'b1; i_start = 1'b0; i_addr_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_val("rst_valid", 32'(o_addr_valid), 0);
    check_val("rst_done", 32'(o_done), 0);
    check_val("rst_addr", 32'(o_cur_addr), 0);
    check_val("rst_nbr_valid", 32'(o_nbr_valid), 0);
    check_val("rst_last", 32'(o_last), 0);

    // Full-speed scan
    i_start = 1'b1; i_addr_ready = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < X * Y; i++) begin
      check_val("run_valid", 32'(o_addr_valid), 1);
      check_val("run_addr", 32'(o_cur_addr), 32'(exp_addr(i)));
      check_val("run_last", 32'(o_last), 32'(i == X * Y - 1));
      check_val("run_xy", {o_cur_y, o_cur_x}, 32'(exp_addr(i) / X * 4 + exp_addr(i) % X));
      if (o_cur_addr == 4'd3) begin
        check_val("nbr_3_valid", 32'(o_nbr_valid), 32'b0110);
        check_val("nbr_3_sw", 32'(slot(o_nbr_addr, 1)), 6);
        check_val("nbr_3_s", 32'(slot(o_nbr_addr, 2)), 7);
        check_val("nbr_3_e0", 32'(slot(o_nbr_addr, 0)), 0);
      end
`ifdef SERPENTINE_EN
      if (o_cur_addr == 4'd7) begin
        check_val("nbr_7_valid", 32'(o_nbr_valid), 32'b1101);
        check_val("nbr_7_w", 32'(slot(o_nbr_addr, 0)), 6);
        check_val("nbr_7_s", 32'(slot(o_nbr_addr, 2)), 11);
        check_val("nbr_7_sw", 32'(slot(o_nbr_addr, 3)), 10);
      end
      if (o_cur_addr == 4'd12) check_val("nbr_12_valid", 32'(o_nbr_valid), 32'b0000);
`else
      if (o_cur_addr == 4'd7) begin
        check_val("nbr_7_valid", 32'(o_nbr_valid), 32'b0110);
        check_val("nbr_7_sw", 32'(slot(o_nbr_addr, 1)), 10);
        check_val("nbr_7_s", 32'(slot(o_nbr_addr, 2)), 11);
      end
      if (o_cur_addr == 4'd12) begin
        check_val("nbr_12_valid", 32'(o_nbr_valid), 32'b0001);
        check_val("nbr_12_e", 32'(slot(o_nbr_addr, 0)), 13);
      end
`endif
      i_start = (i == 5);  // start during a scan must be ignored
      step();
      i_start = 1'b0;
    end
    check_val("done_pulse", 32'(o_done), 1);
    check_val("done_valid", 32'(o_addr_valid), 0);
    step();
    check_val("done_clear", 32'(o_done), 0);
    check_val("idle_valid", 32'(o_addr_valid), 0);

    // Throttled scan: ready alternates, addresses must hold while ready is low
    i_start = 1'b1; i_addr_ready = 1'b0;
    step();
    i_start = 1'b0;
    idx = 0; done_seen = 1'b0;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      if (o_done) begin
        done_seen = 1'b1;
      end else begin
        if (o_addr_valid) check_val("thr_addr", 32'(o_cur_addr), 32'(exp_addr(idx)));
        i_addr_ready = c[0];
        was_acc = o_addr_valid && i_addr_ready;
        step();
        if (was_acc) idx++;
      end
    end
    check_val("thr_done_seen", 32'(done_seen), 1);
    check_val("thr_count", 32'(idx), 16);
    step();
    check_val("thr_idle", 32'(o_addr_valid), 0);

    // Reset mid-scan
    i_start = 1'b1; i_addr_ready = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 20 && o_cur_addr != 4'd9; c++) step();
    check_val("abort_at9", 32'(o_cur_addr), 9);
    rst = 1'b1;
    step();
    check_val("abort_valid", 32'(o_addr_valid), 0);
    check_val("abort_done", 32'(o_done), 0);
    check_val("abort_addr", 32'(o_cur_addr), 0);
    rst = 1'b0;
    step();
    check_val("abort_idle_valid", 32'(o_addr_valid), 0);
    check_val("abort_idle_done", 32'(o_done), 0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_val("restart_valid", 32'(o_addr_valid), 1);
    check_val("restart_addr", 32'(o_cur_addr), 0);
    step();
    check_val("restart_addr1", 32'(o_cur_addr), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
